pc_gen: RTL

- Program-counter stage of the core; sits directly upstream of the ALU operand-1 selector and the instruction-memory address port.
- Produces the current fetch PC, advancing by 4 each cycle.
- Accepts redirects (jump/branch targets) from the ALU.
- After a redirect, holds the target PC and issues pipeline bubbles for FLUSH_CYCLES cycles, so downstream stages drain stale instructions before the new stream starts.

---
 rtl/rysy_pkg.sv | 5 +
 rtl/pc_gen_if.sv | 33 +++
 rtl/pc_gen.sv | 79 +++++++
 3 files changed

// File: rtl/rysy_pkg.sv
// Shared core-wide definitions.
// REG_LEN is the architectural register and address width.
package rysy_pkg;
    localparam int REG_LEN = 32;
endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the PC generator.
// Master drives the PC outputs; slave consumes them and requests redirects.
interface pc_gen_if;
    import rysy_pkg::*;

    logic               stall;
    logic               jump_req;
    logic [REG_LEN-1:0] jump_addr;
    logic [REG_LEN-1:0] pc;
    logic               pc_valid;
    logic               flush;
    logic               misalign;

    modport master (
        input  stall,
        input  jump_req,
        input  jump_addr,
        output pc,
        output pc_valid,
        output flush,
        output misalign
    );

    modport slave (
        output stall,
        output jump_req,
        output jump_addr,
        input  pc,
        input  pc_valid,
        input  flush,
        input  misalign
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter stage: fetch PC, redirects and post-redirect bubbles.
// Define PC_MISALIGN_TRAP_EN to trap misaligned redirects to TRAP_VECTOR.
module pc_gen
    import rysy_pkg::*;
#(
    parameter logic [REG_LEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned        FLUSH_CYCLES = 2,
    parameter logic [REG_LEN-1:0] TRAP_VECTOR  = 32'h0000_0004
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_gen_if.master  bus
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    localparam logic [2:0]         CNT_INIT = 3'(FLUSH_CYCLES);
    localparam logic [REG_LEN-1:0] STEP     = REG_LEN'(4);

    state_t             state;
    logic [2:0]         cnt;
    logic [REG_LEN-1:0] pc_q;
    logic               mis_q;
    logic [REG_LEN-1:0] target;
    logic               bad_align;

`ifdef PC_MISALIGN_TRAP_EN
    assign bad_align = |bus.jump_addr[1:0];
    assign target    = bad_align ? TRAP_VECTOR
                                 : {bus.jump_addr[REG_LEN-1:2], 2'b00};
`else
    logic unused_bits;
    assign unused_bits = ^{TRAP_VECTOR, bus.jump_addr[1:0]};
    assign bad_align   = 1'b0;
    assign target      = {bus.jump_addr[REG_LEN-1:2], 2'b00};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 3'd0;
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
        end else begin
            mis_q <= 1'b0;
            unique case (state)
                RUN: begin
                    if (bus.jump_req) begin
                        pc_q  <= target;
                        cnt   <= CNT_INIT;
                        state <= FLUSH;
                        mis_q <= bad_align;
                    end else if (!bus.stall) begin
                        pc_q <= pc_q + STEP;
                    end
                end
                // redirects are dropped here: their source is being squashed
                FLUSH: begin
                    if (!bus.stall) begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1) begin
                            state <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = (state == RUN);
    assign bus.flush    = (state == FLUSH);
    assign bus.misalign = mis_q;

endmodule
